// File: rtl/rd_uart_tx.sv
// Read-return tap: captures Wishbone read data once per transaction, queues it and sends it as UART 8N1.
// Define RD_UART_PARITY_EN to insert an even-parity bit (8E1 frames).
module rd_uart_tx #(
    parameter int DEPTH_LOG2   = 4,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic                  ack_i,
    input  logic [7:0]            dat_i,
    input  logic                  clr_ovf_i,
    output logic                  dout,
    output logic                  busy_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  ovf_o
);

    localparam int                DEPTH    = 2**DEPTH_LOG2;
    localparam logic [15:0]       BIT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [DEPTH_LOG2:0] FULL   = (DEPTH_LOG2+1)'(DEPTH);

`ifdef RD_UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                  r_state;
    logic [7:0]              r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   r_wptr, r_rptr;
    logic [DEPTH_LOG2:0]     r_count;
    logic                    r_armed, r_ovf;
    logic [15:0]             r_bitcnt;
    logic [2:0]              r_idx;
    logic [7:0]              r_shift;
    logic                    r_dout, r_busy;
`ifdef RD_UART_PARITY_EN
    logic                    r_par;
`endif

    logic                    w_cap, w_full, w_pop, w_push, w_drop, w_idle_nxt;
    logic [DEPTH_LOG2:0]     w_count_nxt;

    // armed re-arms only once stb drops, so a long ack captures a single byte
    assign w_cap  = stb_i & ~we_i & ack_i & r_armed;
    assign w_full = (r_count == FULL);
    assign w_pop  = (r_state == IDLE) & (r_count != '0);
    assign w_push = w_cap & (~w_full | w_pop);
    assign w_drop = w_cap & w_full & ~w_pop;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)
            w_count_nxt = r_count + 1'b1;
        else if (w_pop && !w_push)
            w_count_nxt = r_count - 1'b1;
    end

    assign w_idle_nxt = ((r_state == IDLE) && (r_count == '0)) ||
                        ((r_state == STOP) && (r_bitcnt == '0));

    always_ff @(posedge clk_i) begin
        if (w_push)
            r_mem[r_wptr] <= dat_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_armed <= 1'b1;
            r_ovf   <= 1'b0;
        end else begin
            if (w_cap)
                r_armed <= 1'b0;
            else if (!stb_i)
                r_armed <= 1'b1;
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_nxt;
            if (w_drop)
                r_ovf <= 1'b1;
            else if (clr_ovf_i)
                r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_dout   <= 1'b1;
            r_busy   <= 1'b0;
            r_bitcnt <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
`ifdef RD_UART_PARITY_EN
            r_par    <= 1'b0;
`endif
        end else begin
            // busy tracks the next state/occupancy so it is a clean flop output
            r_busy <= ~w_idle_nxt | (w_count_nxt != '0);
            case (r_state)
                IDLE: begin
                    r_dout <= 1'b1;
                    if (r_count != '0) begin
                        r_shift  <= r_mem[r_rptr];
`ifdef RD_UART_PARITY_EN
                        r_par    <= ^r_mem[r_rptr];
`endif
                        r_dout   <= 1'b0;
                        r_bitcnt <= BIT_LAST;
                        r_state  <= START;
                    end
                end
                START: begin
                    if (r_bitcnt == '0) begin
                        r_dout   <= r_shift[0];
                        r_idx    <= '0;
                        r_bitcnt <= BIT_LAST;
                        r_state  <= DATA;
                    end else
                        r_bitcnt <= r_bitcnt - 1'b1;
                end
                DATA: begin
                    if (r_bitcnt == '0) begin
                        r_shift  <= r_shift >> 1;
                        r_bitcnt <= BIT_LAST;
                        if (r_idx == 3'd7) begin
`ifdef RD_UART_PARITY_EN
                            r_dout  <= r_par;
                            r_state <= PARITY;
`else
                            r_dout  <= 1'b1;
                            r_state <= STOP;
`endif
                        end else begin
                            r_idx  <= r_idx + 1'b1;
                            r_dout <= r_shift[1];
                        end
                    end else
                        r_bitcnt <= r_bitcnt - 1'b1;
                end
`ifdef RD_UART_PARITY_EN
                PARITY: begin
                    if (r_bitcnt == '0) begin
                        r_dout   <= 1'b1;
                        r_bitcnt <= BIT_LAST;
                        r_state  <= STOP;
                    end else
                        r_bitcnt <= r_bitcnt - 1'b1;
                end
`endif
                STOP: begin
                    if (r_bitcnt == '0)
                        r_state <= IDLE;
                    else
                        r_bitcnt <= r_bitcnt - 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dout    = r_dout;
    assign busy_o  = r_busy;
    assign level_o = r_count;
    assign ovf_o   = r_ovf;

endmodule

// File: tb/tb_rd_uart_tx.sv
// Directed bench for rd_uart_tx: a line-level UART receiver decodes dout; results are checked against hand-computed bytes.
module tb_rd_uart_tx;

    localparam int CPB = 4;
    localparam int DL2 = 2;
`ifdef RD_UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FL = FB*CPB;

    logic         clk = 1'b0;
    logic         rst, stb, we, ack, clr;
    logic [7:0]   dat;
    logic         dout, busy, ovf;
    logic [DL2:0] level;

    always #5 clk = ~clk;

    rd_uart_tx #(.DEPTH_LOG2(DL2), .CLKS_PER_BIT(CPB)) dut (
        .clk_i(clk), .rst_i(rst), .stb_i(stb), .we_i(we), .ack_i(ack),
        .dat_i(dat), .clr_ovf_i(clr), .dout(dout), .busy_o(busy),
        .level_o(level), .ovf_o(ovf)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // line receiver: samples each bit slot mid-way on falling clock edges
    int         ncyc = 0;
    bit         rx_on = 1'b0;
    int         rx_rel, rx_slot;
    logic [7:0] rx_sh;
    logic [7:0] rx_q[$];
    int         st_q[$];
    bit         par_q[$];
    int         frm_err = 0;

    always @(negedge clk) begin
        ncyc++;
        if (rst)
            rx_on = 1'b0;
        else if (!rx_on) begin
            if (dout === 1'b0) begin
                rx_on  = 1'b1;
                rx_rel = 0;
                st_q.push_back(ncyc);
            end
        end else begin
            rx_rel++;
            if (rx_rel % CPB == CPB/2) begin
                rx_slot = rx_rel / CPB;
                if (rx_slot == 0) begin
                    if (dout !== 1'b0) frm_err++;
                end else if (rx_slot <= 8)
                    rx_sh[rx_slot-1] = dout;
                else if (rx_slot == FB-1) begin
                    if (dout !== 1'b1) frm_err++;
                    rx_q.push_back(rx_sh);
                    rx_on = 1'b0;
                end else begin
                    par_q.push_back(dout);
                    if (dout !== ^rx_sh) frm_err++;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_rx();
        rx_q.delete();
        st_q.delete();
        par_q.delete();
    endtask

    task automatic rd1(input logic [7:0] b);
        stb = 1'b1; ack = 1'b1; dat = b;
        tick();
        stb = 1'b0; ack = 1'b0;
        tick();
    endtask

    int t_cap;
    int mx;

    initial begin
        rst = 1'b1; stb = 1'b0; we = 1'b0; ack = 1'b0; clr = 1'b0; dat = 8'h00;
        repeat (3) tick();
        chk("rst_dout", dout, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_level", level, 0);
        chk("rst_ovf", ovf, 1'b0);
        rst = 1'b0;
        tick();

        // single read of 0xA5, exact frame timing
        stb = 1'b1; ack = 1'b1; dat = 8'hA5;
        tick();
        stb = 1'b0; ack = 1'b0;
        t_cap = ncyc;
        chk("t1_level_after_cap", level, 1);
        chk("t1_busy_after_cap", busy, 1'b1);
        chk("t1_dout_idle", dout, 1'b1);
        tick();
        chk("t1_start_low", dout, 1'b0);
        chk("t1_latency", (st_q.size() == 1) ? st_q[0] : -1, t_cap + 1);
        repeat (FL-1) tick();
        chk("t1_stop_high", dout, 1'b1);
        chk("t1_busy_last", busy, 1'b1);
        tick();
        chk("t1_busy_end", busy, 1'b0);
        chk("t1_nframes", rx_q.size(), 1);
        chk("t1_byte", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'hA5);
        clear_rx();

        // ack and stb held for 3 cycles: one capture only
        stb = 1'b1; ack = 1'b1; dat = 8'h3C; mx = 0;
        repeat (3) begin
            tick();
            if (int'(level) > mx) mx = int'(level);
        end
        stb = 1'b0; ack = 1'b0;
        repeat (FL+10) tick();
        chk("t2_level_peak", mx, 1);
        chk("t2_nframes", rx_q.size(), 1);
        chk("t2_byte", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h3C);
        clear_rx();

        // write cycle never captures
        stb = 1'b1; we = 1'b1; ack = 1'b1; dat = 8'hFF;
        repeat (3) tick();
        chk("t3_level", level, 0);
        chk("t3_dout", dout, 1'b1);
        chk("t3_busy", busy, 1'b0);
        stb = 1'b0; we = 1'b0; ack = 1'b0;
        repeat (5) tick();
        chk("t3_nframes", rx_q.size(), 0);

        // overflow: one in flight + 4 queued, sixth dropped
        for (int i = 1; i <= 6; i++) rd1(8'(i));
        chk("t4_level_full", level, 4);
        chk("t4_ovf_set", ovf, 1'b1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t4_ovf_clr", ovf, 1'b0);
        repeat (5*(FL+1)+10) tick();
        chk("t4_nframes", rx_q.size(), 5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("t4_byte%0d", i), (rx_q.size() > i) ? rx_q[i] : 8'hxx, 8'(i+1));
        for (int i = 1; i < 5; i++)
            chk($sformatf("t4_gap%0d", i), (st_q.size() > i) ? st_q[i] - st_q[i-1] : -1, FL+1);
        chk("t4_level_drained", level, 0);
        clear_rx();

        // reset in the middle of a data bit
        rd1(8'h55);
        stb = 1'b1; ack = 1'b1; dat = 8'h99;
        tick();
        stb = 1'b0; ack = 1'b0;
        repeat (7) tick();
        chk("t5_pre_rst_dout", dout, 1'b0);
        chk("t5_pre_rst_level", level, 1);
        rst = 1'b1;
        #1;
        chk("t5_rst_dout", dout, 1'b1);
        chk("t5_rst_level", level, 0);
        tick();
        rst = 1'b0;
        tick();
        clear_rx();
        rd1(8'h81);
        repeat (FL+10) tick();
        chk("t5_nframes", rx_q.size(), 1);
        chk("t5_byte", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h81);
        chk("t5_busy", busy, 1'b0);
        clear_rx();

`ifdef RD_UART_PARITY_EN
        rd1(8'h07);
        rd1(8'h03);
        repeat (2*(FL+1)+10) tick();
        chk("t6_nframes", rx_q.size(), 2);
        chk("t6_par0", (par_q.size() > 0) ? par_q[0] : 1'bx, 1'b1);
        chk("t6_par1", (par_q.size() > 1) ? par_q[1] : 1'bx, 1'b0);
        chk("t6_gap", (st_q.size() > 1) ? st_q[1] - st_q[0] : -1, 45);
`endif

        chk("frame_errors", frm_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
